stage_mem: RTL and testbench

Memory-access pipeline stage. It consumes the write-back triple (destination register, write enable, ALU result) produced by the execute stage, together with the load/store request. It performs the data-memory transaction over a req/ack handshake and delivers the final register write-back triple to the MEM/WB boundary. It stalls the upstream pipeline while a memory transaction is outstanding and bounds each transaction with a timeout.

---
 rtl/stage_mem.sv | 230 +++++++++++++++++++++++
 tb/tb_stage_mem.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_mem.sv
// Memory-access pipeline stage: turns EX results plus a load/store request into one
// req/ack data-memory transaction and a single registered MEM/WB write-back pulse.
module stage_mem #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  input  logic [4:0]  reg_waddr_i,
  input  logic        we_i,
  input  logic [31:0] reg_wdata_i,
  input  logic [3:0]  mem_op,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_req,
  output logic        out_valid,
  output logic [4:0]  reg_waddr_o,
  output logic        we_o,
  output logic [31:0] reg_wdata_o,
  output logic        exc_misalign,
  output logic        exc_bus
);

  localparam logic [3:0] OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3, OP_LBU = 4'd4,
                         OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;
  localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state_reg, state_next;
  logic        mem_req_reg, mem_req_next, mem_we_reg, mem_we_next;
  logic [31:0] mem_addr_reg, mem_addr_next, mem_wdata_reg, mem_wdata_next;
  logic [3:0]  mem_be_reg, mem_be_next;
  logic        out_valid_reg, out_valid_next, we_o_reg, we_o_next;
  logic [4:0]  reg_waddr_o_reg, reg_waddr_o_next;
  logic [31:0] reg_wdata_o_reg, reg_wdata_o_next;
  logic        exc_misalign_reg, exc_misalign_next, exc_bus_reg, exc_bus_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [3:0]  op_reg, op_next;
  logic [4:0]  waddr_reg, waddr_next;
  logic        we_reg, we_next, flush_reg, flush_next;
  logic [1:0]  addr_lo_reg, addr_lo_next;

  logic        op_load, op_store, op_byte, op_half, op_word;
  logic        misalign, aligned_mem, accept, killed;
  logic [3:0]  be_in;
  logic [31:0] wdata_in, load_data;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Request decode on the incoming instruction
  always_comb begin
    op_load     = mem_op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    op_store    = mem_op inside {OP_SB, OP_SH, OP_SW};
    op_byte     = mem_op inside {OP_LB, OP_LBU, OP_SB};
    op_half     = mem_op inside {OP_LH, OP_LHU, OP_SH};
    op_word     = mem_op inside {OP_LW, OP_SW};
    misalign    = (op_half & reg_wdata_i[0]) | (op_word & (reg_wdata_i[1:0] != 2'b00));
    aligned_mem = (op_load | op_store) & ~misalign;
    accept      = (state_reg == IDLE) & in_valid & ~flush;
    be_in       = 4'b1111;
    wdata_in    = store_data;
    if (op_byte) begin
      be_in    = 4'b0001 << reg_wdata_i[1:0];
      wdata_in = {4{store_data[7:0]}};
    end else if (op_half) begin
      be_in    = reg_wdata_i[1] ? 4'b1100 : 4'b0011;
      wdata_in = {2{store_data[15:0]}};
    end
  end

  // Lane extraction for the latched load
  always_comb begin
    case (addr_lo_reg)
      2'd0:    lane_byte = mem_rdata[7:0];
      2'd1:    lane_byte = mem_rdata[15:8];
      2'd2:    lane_byte = mem_rdata[23:16];
      default: lane_byte = mem_rdata[31:24];
    endcase
    lane_half = addr_lo_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_reg)
      OP_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
      OP_LBU:  load_data = {24'd0, lane_byte};
      OP_LH:   load_data = {{16{lane_half[15]}}, lane_half};
      OP_LHU:  load_data = {16'd0, lane_half};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_next        = state_reg;
    mem_req_next      = mem_req_reg;
    mem_we_next       = mem_we_reg;
    mem_addr_next     = mem_addr_reg;
    mem_wdata_next    = mem_wdata_reg;
    mem_be_next       = mem_be_reg;
    out_valid_next    = 1'b0;
    exc_misalign_next = 1'b0;
    exc_bus_next      = 1'b0;
    we_o_next         = we_o_reg;
    reg_waddr_o_next  = reg_waddr_o_reg;
    reg_wdata_o_next  = reg_wdata_o_reg;
    cnt_next          = cnt_reg;
    op_next           = op_reg;
    waddr_next        = waddr_reg;
    we_next           = we_reg;
    addr_lo_next      = addr_lo_reg;
    flush_next        = flush_reg;
    killed            = flush_reg | flush;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (!(op_load | op_store)) begin
            out_valid_next   = 1'b1;
            reg_waddr_o_next = reg_waddr_i;
            we_o_next        = we_i;
            reg_wdata_o_next = reg_wdata_i;
          end else if (misalign) begin
            out_valid_next    = 1'b1;
            exc_misalign_next = 1'b1;
            reg_waddr_o_next  = reg_waddr_i;
            we_o_next         = 1'b0;
            reg_wdata_o_next  = reg_wdata_i;
          end else begin
            state_next     = WAIT;
            mem_req_next   = 1'b1;
            mem_we_next    = op_store;
            mem_addr_next  = {reg_wdata_i[31:2], 2'b00};
            mem_be_next    = be_in;
            mem_wdata_next = wdata_in;
            cnt_next       = 8'd0;
            op_next        = mem_op;
            waddr_next     = reg_waddr_i;
            we_next        = we_i;
            addr_lo_next   = reg_wdata_i[1:0];
            flush_next     = 1'b0;
          end
        end
      end
      WAIT: begin
        flush_next = killed;
        if (mem_ack || cnt_reg == CNT_LAST) begin
          state_next   = IDLE;
          mem_req_next = 1'b0;
          if (!killed) begin
            out_valid_next   = 1'b1;
            reg_waddr_o_next = waddr_reg;
            we_o_next        = 1'b0;
            if (!mem_ack) begin
              exc_bus_next = 1'b1;
            end else if (mem_we_reg) begin
              reg_wdata_o_next = 32'd0;
            end else begin
              we_o_next        = we_reg;
              reg_wdata_o_next = load_data;
            end
          end
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      mem_req_reg      <= 1'b0;
      mem_we_reg       <= 1'b0;
      mem_addr_reg     <= 32'd0;
      mem_wdata_reg    <= 32'd0;
      mem_be_reg       <= 4'd0;
      out_valid_reg    <= 1'b0;
      we_o_reg         <= 1'b0;
      reg_waddr_o_reg  <= 5'd0;
      reg_wdata_o_reg  <= 32'd0;
      exc_misalign_reg <= 1'b0;
      exc_bus_reg      <= 1'b0;
      cnt_reg          <= 8'd0;
      op_reg           <= 4'd0;
      waddr_reg        <= 5'd0;
      we_reg           <= 1'b0;
      addr_lo_reg      <= 2'd0;
      flush_reg        <= 1'b0;
    end else begin
      state_reg        <= state_next;
      mem_req_reg      <= mem_req_next;
      mem_we_reg       <= mem_we_next;
      mem_addr_reg     <= mem_addr_next;
      mem_wdata_reg    <= mem_wdata_next;
      mem_be_reg       <= mem_be_next;
      out_valid_reg    <= out_valid_next;
      we_o_reg         <= we_o_next;
      reg_waddr_o_reg  <= reg_waddr_o_next;
      reg_wdata_o_reg  <= reg_wdata_o_next;
      exc_misalign_reg <= exc_misalign_next;
      exc_bus_reg      <= exc_bus_next;
      cnt_reg          <= cnt_next;
      op_reg           <= op_next;
      waddr_reg        <= waddr_next;
      we_reg           <= we_next;
      addr_lo_reg      <= addr_lo_next;
      flush_reg        <= flush_next;
    end
  end

  assign in_ready     = (state_reg == IDLE);
  assign stall_req    = (state_reg == WAIT) | ((state_reg == IDLE) & in_valid & aligned_mem & ~flush);
  assign mem_req      = mem_req_reg;
  assign mem_we       = mem_we_reg;
  assign mem_addr     = mem_addr_reg;
  assign mem_wdata    = mem_wdata_reg;
  assign mem_be       = mem_be_reg;
  assign out_valid    = out_valid_reg;
  assign we_o         = we_o_reg;
  assign reg_waddr_o  = reg_waddr_o_reg;
  assign reg_wdata_o  = reg_wdata_o_reg;
  assign exc_misalign = exc_misalign_reg;
  assign exc_bus      = exc_bus_reg;

endmodule

// File: tb/tb_stage_mem.sv
// Directed bench for stage_mem: transaction-level reference model checked every cycle,
// plus literal expectations from hand-worked examples.
module tb_stage_mem;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, we_i, mem_req, mem_we, mem_ack, stall_req;
  logic        out_valid, we_o, exc_misalign, exc_bus;
  logic [4:0]  reg_waddr_i, reg_waddr_o;
  logic [31:0] reg_wdata_i, store_data, mem_addr, mem_wdata, mem_rdata, reg_wdata_o;
  logic [3:0]  mem_op, mem_be;

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  stage_mem #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .reg_waddr_i(reg_waddr_i), .we_i(we_i), .reg_wdata_i(reg_wdata_i), .mem_op(mem_op),
    .store_data(store_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_req(stall_req), .out_valid(out_valid), .reg_waddr_o(reg_waddr_o), .we_o(we_o),
    .reg_wdata_o(reg_wdata_o), .exc_misalign(exc_misalign), .exc_bus(exc_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Access-size view of the op code: 0 means no memory access
  function automatic int size_of(input logic [3:0] op);
    case (op)
      4'd1, 4'd4, 4'd6: return 1;
      4'd2, 4'd5, 4'd7: return 2;
      4'd3, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic bit misaligned(input logic [3:0] op, input logic [31:0] a);
    int sz = size_of(op);
    return (sz != 0) && ((a % sz) != 0);
  endfunction

  function automatic logic [3:0] be_of(input logic [3:0] op, input logic [31:0] a);
    int sz = size_of(op);
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] wdata_of(input logic [3:0] op, input logic [31:0] sd);
    int sz = size_of(op);
    if (sz == 1) return {24'd0, sd[7:0]} * 32'h0101_0101;
    if (sz == 2) return {16'd0, sd[15:0]} * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] load_of(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] rd);
    int sz = size_of(op);
    logic [31:0] mask, v;
    mask = (sz == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * sz)) - 64'd1);
    v = (rd >> (8 * (a % 4))) & mask;
    if ((op == 4'd1 || op == 4'd2) && v[8 * sz - 1]) v = v | ~mask;
    return v;
  endfunction

  // Reference model: one outstanding transaction, updated from pre-edge inputs
  bit          m_busy, m_killed, m_store;
  int          m_wait;
  logic [3:0]  m_op;
  logic [31:0] m_addr;
  logic [4:0]  m_waddr;
  logic        m_we;
  bit          e_valid, e_mis, e_bus, e_req, e_data_known, e_mem_we;
  logic [4:0]  e_waddr;
  logic        e_we;
  logic [31:0] e_wdata, e_addr, e_mwdata;
  logic [3:0]  e_be;

  always @(posedge clk) begin
    e_valid = 0; e_mis = 0; e_bus = 0;
    if (rst) begin
      m_busy = 0; e_req = 0;
    end else if (!m_busy) begin
      if (in_valid && !flush) begin
        if (size_of(mem_op) == 0) begin
          e_valid = 1; e_waddr = reg_waddr_i; e_we = we_i; e_wdata = reg_wdata_i; e_data_known = 1;
        end else if (misaligned(mem_op, reg_wdata_i)) begin
          e_valid = 1; e_mis = 1; e_waddr = reg_waddr_i; e_we = 0; e_wdata = reg_wdata_i;
          e_data_known = 1;
        end else begin
          m_busy = 1; m_killed = 0; m_wait = 0; m_op = mem_op; m_addr = reg_wdata_i;
          m_waddr = reg_waddr_i; m_we = we_i; m_store = (mem_op >= 4'd6);
          e_req = 1; e_mem_we = m_store; e_addr = reg_wdata_i & 32'hFFFF_FFFC;
          e_be = be_of(mem_op, reg_wdata_i); e_mwdata = wdata_of(mem_op, store_data);
        end
      end
    end else begin
      m_killed = m_killed || flush;
      if (!mem_ack) m_wait++;
      if (mem_ack || m_wait == TO) begin
        m_busy = 0; e_req = 0;
        if (!m_killed) begin
          e_valid = 1; e_waddr = m_waddr; e_we = 0;
          if (!mem_ack) begin
            e_bus = 1; e_data_known = 0;
          end else if (m_store) begin
            e_wdata = 32'd0; e_data_known = 1;
          end else begin
            e_we = m_we; e_wdata = load_of(m_op, m_addr, mem_rdata); e_data_known = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", 32'(out_valid), 32'(e_valid));
      check("exc_misalign", 32'(exc_misalign), 32'(e_mis));
      check("exc_bus", 32'(exc_bus), 32'(e_bus));
      check("mem_req", 32'(mem_req), 32'(e_req));
      check("in_ready", 32'(in_ready), 32'(!m_busy));
      check("stall_req", 32'(stall_req), 32'(m_busy || (in_valid && !flush &&
            size_of(mem_op) != 0 && !misaligned(mem_op, reg_wdata_i))));
      if (e_valid) begin
        check("reg_waddr_o", 32'(reg_waddr_o), 32'(e_waddr));
        check("we_o", 32'(we_o), 32'(e_we));
        if (e_data_known) check("reg_wdata_o", reg_wdata_o, e_wdata);
      end
      if (e_req) begin
        check("mem_addr", mem_addr, e_addr);
        check("mem_be", 32'(mem_be), 32'(e_be));
        check("mem_we", 32'(mem_we), 32'(e_mem_we));
        check("mem_wdata", mem_wdata, e_mwdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] wa, input logic we);
    in_valid = 1; mem_op = op; reg_wdata_i = a; store_data = sd; reg_waddr_i = wa; we_i = we;
    tick();
    in_valid = 0; mem_op = 4'd0;
    $display("issue op=%0d addr=%h sd=%h rd=%0d we=%0d", op, a, sd, wa, we);
  endtask

  task automatic ack_after(input int n, input logic [31:0] rd);
    repeat (n) tick();
    mem_ack = 1; mem_rdata = rd;
    tick();
    mem_ack = 0;
    $display("ack rdata=%h -> out_valid=%0d we_o=%0d wdata=%h", rd, out_valid, we_o, reg_wdata_o);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1; in_valid = 0; flush = 0; we_i = 0; mem_ack = 0; reg_waddr_i = 0;
    reg_wdata_i = 0; store_data = 0; mem_rdata = 0; mem_op = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0; chk_en = 1;
    check("rst mem_req", 32'(mem_req), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst reg_wdata_o", reg_wdata_o, 32'd0);

    // NONE, then back-to-back NONE and a flushed NONE
    in_valid = 1; mem_op = 0; reg_waddr_i = 5; we_i = 1; reg_wdata_i = 32'h1234;
    #1 check("none stall", 32'(stall_req), 32'd0);
    tick();
    check("none valid", 32'(out_valid), 32'd1);
    check("none waddr", 32'(reg_waddr_o), 32'd5);
    check("none we", 32'(we_o), 32'd1);
    check("none wdata", reg_wdata_o, 32'h1234);
    reg_waddr_i = 6; reg_wdata_i = 32'h55;
    tick();
    check("b2b wdata", reg_wdata_o, 32'h55);
    flush = 1;
    tick();
    flush = 0; in_valid = 0;
    check("flushed none", 32'(out_valid), 32'd0);

    // LB / LBU at 0x103
    issue(4'd1, 32'h103, 0, 5'd7, 1);
    check("lb mem_addr", mem_addr, 32'h100);
    check("lb mem_be", 32'(mem_be), 32'h8);
    ack_after(2, 32'h80FF_0000);
    check("lb data", reg_wdata_o, 32'hFFFF_FF80);
    check("lb we", 32'(we_o), 32'd1);
    issue(4'd4, 32'h103, 0, 5'd8, 1);
    ack_after(2, 32'h80FF_0000);
    check("lbu data", reg_wdata_o, 32'h0000_0080);

    // SH at 0x202, fastest ack
    issue(4'd7, 32'h202, 32'hAAAA_BEEF, 5'd9, 1);
    check("sh mem_be", 32'(mem_be), 32'hC);
    check("sh mem_wdata", mem_wdata, 32'hBEEF_BEEF);
    check("sh mem_we", 32'(mem_we), 32'd1);
    ack_after(0, 32'h0);
    check("sh valid", 32'(out_valid), 32'd1);
    check("sh we", 32'(we_o), 32'd0);

    // More lanes and sizes, checked by the model
    issue(4'd6, 32'h301, 32'h1234_5678, 5'd1, 1); ack_after(1, 32'h0);
    issue(4'd8, 32'h400, 32'hCAFE_F00D, 5'd2, 1); ack_after(0, 32'h0);
    issue(4'd2, 32'h502, 0, 5'd3, 1);             ack_after(1, 32'h8001_7FFF);
    check("lh data", reg_wdata_o, 32'hFFFF_8001);
    issue(4'd5, 32'h500, 0, 5'd4, 1);             ack_after(0, 32'h8001_F00F);
    check("lhu data", reg_wdata_o, 32'h0000_F00F);
    issue(4'd3, 32'h600, 0, 5'd10, 1);            ack_after(3, 32'hDEAD_BEEF);
    issue(4'd7, 32'h203, 32'h1, 5'd11, 1);

    // Misaligned LW
    issue(4'd3, 32'h6, 0, 5'd12, 1);
    check("mis mem_req", 32'(mem_req), 32'd0);
    check("mis valid", 32'(out_valid), 32'd1);
    check("mis exc", 32'(exc_misalign), 32'd1);
    check("mis we", 32'(we_o), 32'd0);
    check("mis wdata", reg_wdata_o, 32'h6);

    // ack while idle is ignored
    mem_ack = 1; tick(); mem_ack = 0;
    check("idle ack", 32'(out_valid), 32'd0);

    // Timeout
    issue(4'd3, 32'h40, 0, 5'd13, 1);
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      tick();
    end
    $display("timeout: mem_req high %0d cycles", n);
    check("timeout req cycles", 32'(n), 32'(TO));
    check("timeout valid", 32'(out_valid), 32'd1);
    check("timeout exc_bus", 32'(exc_bus), 32'd1);
    check("timeout we", 32'(we_o), 32'd0);
    check("timeout in_ready", 32'(in_ready), 32'd1);

    // flush in WAIT
    issue(4'd3, 32'h80, 0, 5'd14, 1);
    tick(); flush = 1; tick(); flush = 0;
    ack_after(1, 32'h1111_2222);
    check("flush valid", 32'(out_valid), 32'd0);
    check("flush in_ready", 32'(in_ready), 32'd1);

    // reset in WAIT, then a late ack
    issue(4'd3, 32'h84, 0, 5'd15, 1);
    tick(); rst = 1; tick(); rst = 0;
    check("wrst mem_req", 32'(mem_req), 32'd0);
    check("wrst mem_be", 32'(mem_be), 32'd0);
    check("wrst we_o", 32'(we_o), 32'd0);
    mem_ack = 1; tick(); mem_ack = 0;
    check("late ack valid", 32'(out_valid), 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
